// File: rtl/rggen_axi4lite_wishbone_bridge.sv
// AXI4-Lite slave to pipelined Wishbone master bridge with a single outstanding
// access and round-robin arbitration between write pairs and reads.
module rggen_axi4lite_wishbone_bridge #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  // AXI4-Lite host side
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic [2:0]               awprot,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic [BUS_WIDTH/8-1:0]   wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [2:0]               arprot,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [1:0]               rresp,
  output logic [BUS_WIDTH-1:0]     rdata,
  // Wishbone side
  output logic                     cyc,
  output logic                     stb,
  input  logic                     stall,
  output logic [ADDRESS_WIDTH-1:0] adr,
  output logic                     we,
  output logic [BUS_WIDTH-1:0]     dat_w,
  output logic [BUS_WIDTH/8-1:0]   sel,
  input  logic                     ack,
  input  logic                     err,
  input  logic                     rty,
  input  logic [BUS_WIDTH-1:0]     dat_r
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WB_REQ  = 2'd1;
  localparam logic [1:0] WB_WAIT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [1:0]               state_reg;
  logic [1:0]               state_next;
  logic                     write_prio_reg;
  logic [ADDRESS_WIDTH-1:0] adr_reg;
  logic                     we_reg;
  logic [BUS_WIDTH-1:0]     dat_w_reg;
  logic [BUS_WIDTH/8-1:0]   sel_reg;
  logic [1:0]               resp_reg;
  logic [BUS_WIDTH-1:0]     rdata_reg;

  logic write_req;
  logic read_req;
  logic grant_write;
  logic grant_read;
  logic term;
  logic wb_done;
  logic resp_done;
  logic unused_prot;

  assign unused_prot = ^{awprot, arprot};

  assign write_req = awvalid & wvalid;
  assign read_req  = arvalid;

  // Readies are qualified by reset so nothing is granted while held in reset.
  assign grant_write = (state_reg == IDLE) & i_rst_n & write_req
                     & (~read_req | write_prio_reg);
  assign grant_read  = (state_reg == IDLE) & i_rst_n & read_req
                     & (~write_req | ~write_prio_reg);

  assign term      = ack | err | rty;
  assign wb_done   = ((state_reg == WB_REQ) & ~stall & term)
                   | ((state_reg == WB_WAIT) & term);
  assign resp_done = (state_reg == RESP) & (we_reg ? bready : rready);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_write | grant_read) state_next = WB_REQ;
      WB_REQ:  if (!stall) state_next = term ? RESP : WB_WAIT;
      WB_WAIT: if (term) state_next = RESP;
      RESP:    if (resp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      write_prio_reg <= 1'b1;
      adr_reg        <= '0;
      we_reg         <= 1'b0;
      dat_w_reg      <= '0;
      sel_reg        <= '0;
      resp_reg       <= OKAY;
      rdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      // The pointer only moves on contention: the loser wins next time.
      if ((state_reg == IDLE) && write_req && read_req) begin
        write_prio_reg <= ~grant_write;
      end
      if (grant_write) begin
        adr_reg   <= awaddr;
        we_reg    <= 1'b1;
        dat_w_reg <= wdata;
        sel_reg   <= wstrb;
      end else if (grant_read) begin
        adr_reg   <= araddr;
        we_reg    <= 1'b0;
        dat_w_reg <= '0;
        sel_reg   <= '1;
      end
      if (wb_done) begin
        resp_reg <= (err | rty) ? SLVERR : OKAY;
        if (!we_reg) begin
          rdata_reg <= dat_r;
        end
      end
    end
  end

  assign awready = grant_write;
  assign wready  = grant_write;
  assign arready = grant_read;

  assign cyc   = (state_reg == WB_REQ) | (state_reg == WB_WAIT);
  assign stb   = (state_reg == WB_REQ);
  assign adr   = adr_reg;
  assign we    = we_reg;
  assign dat_w = dat_w_reg;
  assign sel   = sel_reg;

  assign bvalid = (state_reg == RESP) & we_reg;
  assign rvalid = (state_reg == RESP) & ~we_reg;
  assign bresp  = resp_reg;
  assign rresp  = resp_reg;
  assign rdata  = rdata_reg;

endmodule

// File: tb/tb_rggen_axi4lite_wishbone_bridge.sv
// Bench for the AXI4-Lite to Wishbone bridge: directed table, randomized
// transactions against a rule-level model, and multi-cycle corner sequences.
module tb_rggen_axi4lite_wishbone_bridge;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic          bready = 1'b0, rready = 1'b0;
  logic          awready, wready, arready, bvalid, rvalid;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0]    awprot = 3'd0, arprot = 3'd0;
  logic [BW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic [1:0]    bresp, rresp;
  logic [BW-1:0] rdata;
  logic          cyc, stb, we;
  logic          stall = 1'b0, ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic [AW-1:0] adr;
  logic [BW-1:0] dat_w;
  logic [SW-1:0] sel;
  logic [BW-1:0] dat_r = '0;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  rggen_axi4lite_wishbone_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
    .cyc(cyc), .stb(stb), .stall(stall), .adr(adr), .we(we),
    .dat_w(dat_w), .sel(sel), .ack(ack), .err(err), .rty(rty), .dat_r(dat_r)
  );

  // term = {rty, err, ack}; wait_n = 0 terminates in the request cycle itself
  typedef struct {
    bit            is_write;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic [SW-1:0] strb;
    int            stall_n;
    int            wait_n;
    logic [2:0]    term;
    bit            noise;
    logic [BW-1:0] dat_r;
    int            bready_n;
    bit            ar_pending;
  } txn_t;

  typedef struct {
    txn_t          t;
    logic [1:0]    exp_resp;
    logic [BW-1:0] exp_rdata;
    bit            chk_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                              input logic [SW-1:0] s, input int st, input int wt,
                              input logic [2:0] tm, input bit nz, input logic [BW-1:0] dr,
                              input int br);
    txn_t t;
    t.is_write = w; t.addr = a; t.data = d; t.strb = s; t.stall_n = st; t.wait_n = wt;
    t.term = tm; t.noise = nz; t.dat_r = dr; t.bready_n = br; t.ar_pending = 1'b0;
    return t;
  endfunction

  task automatic drive_term(input txn_t t);
    ack = t.term[0]; err = t.term[1]; rty = t.term[2]; dat_r = t.dat_r;
  endtask

  task automatic clear_term(input txn_t t);
    ack = 1'b0; err = 1'b0; rty = 1'b0; dat_r = ~t.dat_r;
  endtask

  task automatic run_txn(input txn_t t, input logic [1:0] exp_resp,
                         input logic [BW-1:0] exp_rdata, input bit chk_rdata);
    bit            got;
    bit            ok;
    logic [1:0]    idle_v;
    logic [SW-1:0] exp_sel;
    logic [BW-1:0] exp_datw;
    exp_sel  = t.is_write ? t.strb : '1;
    exp_datw = t.is_write ? t.data : '0;
    dat_r    = ~t.dat_r;
    idle_v   = 2'b00;
    if (t.is_write) begin
      awvalid = 1'b1; wvalid = 1'b1; awaddr = t.addr; wdata = t.data; wstrb = t.strb;
    end else begin
      arvalid = 1'b1; araddr = t.addr;
    end
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge i_clk);
      if (n == 0) idle_v = {bvalid, rvalid};
      if (t.is_write ? (awready && wready && !arready) : (arready && !awready && !wready))
        got = 1'b1;
      @(posedge i_clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("idle_valid", idle_v, 0);
    chk("accept", got, 1);
    if (!got) return;
    ok = 1'b1;
    for (int s = 0; s < t.stall_n; s++) begin
      stall = 1'b1; ack = t.noise;
      @(negedge i_clk);
      if (!(cyc && stb && adr == t.addr && we == t.is_write && sel == exp_sel &&
            dat_w == exp_datw && !bvalid && !rvalid)) ok = 1'b0;
      @(posedge i_clk); #1;
    end
    stall = 1'b0; ack = 1'b0;
    if (t.stall_n > 0) chk("stall_hold", ok, 1);
    if (t.wait_n == 0) drive_term(t);
    @(negedge i_clk);
    chk("cyc_stb", {cyc, stb}, 2'b11);
    chk("adr", adr, t.addr);
    chk("we", we, t.is_write);
    chk("sel", sel, exp_sel);
    chk("dat_w", dat_w, exp_datw);
    @(posedge i_clk); #1;
    clear_term(t);
    ok = 1'b1;
    for (int w = 1; w <= t.wait_n; w++) begin
      if (w == t.wait_n) drive_term(t);
      @(negedge i_clk);
      if (!(cyc && !stb && !bvalid && !rvalid)) ok = 1'b0;
      @(posedge i_clk); #1;
      clear_term(t);
    end
    if (t.wait_n > 0) chk("wait_phase", ok, 1);
    if (t.ar_pending) begin
      arvalid = 1'b1; araddr = t.addr ^ 8'h40;
    end
    ok = 1'b1;
    for (int b = 0; b < t.bready_n; b++) begin
      @(negedge i_clk);
      if (!(bvalid == t.is_write && rvalid == !t.is_write && !cyc && !arready && !awready &&
            (t.is_write ? bresp : rresp) == exp_resp)) ok = 1'b0;
      @(posedge i_clk); #1;
    end
    if (t.bready_n > 0) chk("resp_hold", ok, 1);
    if (t.is_write) bready = 1'b1; else rready = 1'b1;
    @(negedge i_clk);
    chk(t.is_write ? "bvalid" : "rvalid", t.is_write ? bvalid : rvalid, 1);
    chk("other_valid", t.is_write ? rvalid : bvalid, 0);
    chk("cyc_end", cyc, 0);
    chk("resp", t.is_write ? bresp : rresp, exp_resp);
    if (chk_rdata) chk("rdata", rdata, exp_rdata);
    if (t.ar_pending) chk("ar_blocked", arready, 0);
    @(posedge i_clk); #1;
    bready = 1'b0; rready = 1'b0;
    $display("[TB] %s addr=0x%02h stall=%0d wait=%0d term=%b resp=%0d rdata=0x%08h",
             t.is_write ? "WR" : "RD", t.addr, t.stall_n, t.wait_n, t.term,
             t.is_write ? bresp : rresp, rdata);
  endtask

  // Completes an already-accepted access with a plain one-cycle ack.
  task automatic finish_simple(input string name);
    bit got;
    got = 1'b0;
    stall = 1'b0;
    @(posedge i_clk); #1; ack = 1'b1;
    @(posedge i_clk); #1; ack = 1'b0; bready = 1'b1; rready = 1'b1;
    for (int n = 0; n < 5 && !got; n++) begin
      @(negedge i_clk);
      if (bvalid || rvalid) got = 1'b1;
      @(posedge i_clk); #1;
    end
    bready = 1'b0; rready = 1'b0;
    chk(name, got, 1);
    $display("[TB] %s completed", name);
  endtask

  task automatic contend(input bit exp_write);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 8'h30; araddr = 8'h34; wdata = 32'h0000_3030; wstrb = '1;
    @(negedge i_clk);
    chk("arb_aw", awready, exp_write);
    chk("arb_w", wready, exp_write);
    chk("arb_ar", arready, !exp_write);
    @(posedge i_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge i_clk);
    chk("arb_we", we, exp_write);
    finish_simple(exp_write ? "arb_write_done" : "arb_read_done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required completion in time");
    $fatal(1);
  end

  initial begin
    bit   ok;
    txn_t t;

    vecs[0] = '{mk(1, 8'h10, 32'hA5A5_0001, 4'hF, 0, 1, 3'b001, 0, 32'h0, 0), 2'b00, 32'h0, 0};
    vecs[1] = '{mk(0, 8'h14, 32'h0, 4'h0, 3, 1, 3'b001, 1, 32'h1234_5678, 0), 2'b00, 32'h1234_5678, 1};
    vecs[2] = '{mk(0, 8'h18, 32'h0, 4'h0, 0, 2, 3'b010, 0, 32'hDEAD_BEEF, 1), 2'b10, 32'hDEAD_BEEF, 1};
    vecs[3] = '{mk(1, 8'h20, 32'h0BAD_F00D, 4'h3, 1, 0, 3'b100, 0, 32'h0, 0), 2'b10, 32'h0, 0};
    vecs[4] = '{mk(0, 8'h24, 32'h0, 4'h0, 0, 0, 3'b011, 0, 32'hCAFE_0000, 0), 2'b10, 32'hCAFE_0000, 1};
    vecs[5] = '{mk(1, 8'hFC, 32'hFFFF_0000, 4'h0, 0, 3, 3'b001, 0, 32'h0, 2), 2'b00, 32'h0, 0};

    // Reset state, with valids asserted to confirm nothing is granted.
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_wb", {cyc, stb, we, adr, dat_w, sel}, 0);
    chk("rst_ready", {awready, wready, arready}, 0);
    chk("rst_resp", {bvalid, rvalid, bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].t, vecs[i].exp_resp, vecs[i].exp_rdata, vecs[i].chk_rdata);
    end

    // Randomized accesses; expectations follow the response rules directly.
    for (int i = 0; i < 24; i++) begin
      t = mk($urandom_range(0, 1), AW'($urandom), $urandom, SW'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), 3'($urandom_range(1, 7)),
             $urandom_range(0, 1), $urandom, $urandom_range(0, 3));
      run_txn(t, ((t.term & 3'b110) != 0) ? 2'b10 : 2'b00, t.dat_r,
              !t.is_write && ((t.term & 3'b011) != 0));
    end

    contend(1'b1);
    contend(1'b0);
    contend(1'b1);

    // Address without data must not be accepted.
    awvalid = 1'b1; awaddr = 8'h44; ok = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge i_clk);
      if (awready || wready || cyc) ok = 1'b0;
      @(posedge i_clk); #1;
    end
    chk("aw_only", ok, 1);
    wvalid = 1'b1; wdata = 32'h0000_4444; wstrb = '1;
    @(negedge i_clk);
    chk("aw_w_accept", {awready, wready}, 2'b11);
    @(posedge i_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    finish_simple("aw_w_done");

    // Back-pressured write response with a read waiting behind it.
    t = mk(1, 8'h48, 32'h5555_AAAA, 4'hF, 0, 1, 3'b001, 0, 32'h0, 5);
    t.ar_pending = 1'b1;
    run_txn(t, 2'b00, 32'h0, 0);
    @(negedge i_clk);
    chk("ar_after_hs", arready, 1);
    @(posedge i_clk); #1;
    arvalid = 1'b0;
    finish_simple("pending_read_done");

    // Reset in WB_WAIT aborts the access; a late ack must not produce a response.
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'h50; wdata = 32'h0000_5050; wstrb = '1;
    @(posedge i_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; stall = 1'b0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("pre_rst_cyc", {cyc, stb}, 2'b10);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_async", {cyc, stb, bvalid, rvalid}, 0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1; ack = 1'b1;
    @(posedge i_clk); #1;
    ack = 1'b0; ok = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge i_clk);
      if (bvalid || rvalid || cyc) ok = 1'b0;
      @(posedge i_clk); #1;
    end
    chk("no_late_resp", ok, 1);
    $display("[TB] reset abort sequence done");

    // Pointer was favouring read before reset; reset restores write priority.
    contend(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rggen_axi4lite_wishbone_bridge.md
RGGEN_AXI4LITE_WISHBONE_BRIDGE -- requirements
Module: rggen_axi4lite_wishbone_bridge

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: byte address width on both ports.
REQ-002 Parameter BUS_WIDTH, default 32: data width on both ports, 32 or 64.
REQ-003 i_clk  input  1  clock; single clock domain; all state is updated on the rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 axi4lite_if  rggen_axi4lite_if.slave  ADDRESS_WIDTH/BUS_WIDTH  upstream AXI4-Lite host port; *prot is ignored.
REQ-006 wishbone_if  rggen_wishbone_if.master  ADDRESS_WIDTH/BUS_WIDTH  pipelined Wishbone port that feeds the register-block Wishbone adapter.

Function
REQ-007 The block SHALL be a single-outstanding bridge built around FSM states IDLE, WB_REQ, WB_WAIT and RESP.
REQ-008 In IDLE, write acceptance SHALL need awvalid and wvalid both high; awready and wready SHALL pulse together for one cycle; one channel alone SHALL NOT be accepted.
REQ-009 In IDLE, read acceptance SHALL need arvalid; arready SHALL pulse for one cycle.
REQ-010 When a write pair and a read are both valid in IDLE, the block SHALL arbitrate round-robin: write wins first after reset, and the other type wins the next contention.
REQ-011 awready, wready and arready SHALL be 0 in every state except IDLE.
REQ-012 On acceptance, the block SHALL register adr, we, dat_w and sel: sel = wstrb for writes, all ones for reads, dat_w = 0 for reads; then go to WB_REQ.
REQ-013 In WB_REQ, cyc and stb SHALL be 1 and adr/we/dat_w/sel SHALL be held stable.
REQ-014 In WB_REQ, when stall = 0 the request is accepted: stb SHALL drop the next cycle and the FSM SHALL go to WB_WAIT.
REQ-015 If ack, err or rty arrives in WB_REQ together with stall = 0, the FSM SHALL go directly to RESP; ack/err/rty SHALL be ignored while stall = 1.
REQ-016 In WB_WAIT, cyc SHALL be 1 and stb SHALL be 0.
REQ-017 In WB_WAIT, the first cycle with ack, err or rty high SHALL end the cycle; cyc SHALL be 0 from the next cycle.
REQ-018 On termination, response code SHALL be OKAY (2'b00) for ack and SLVERR (2'b10) for err or rty; err SHALL take priority if several are high together.
REQ-019 For reads, rdata SHALL capture dat_r on termination, for both ack and err.
REQ-020 In RESP, bvalid (write) or rvalid (read) SHALL be 1 with bresp/rresp and rdata held stable until bready/rready is high; then the FSM SHALL return to IDLE.
REQ-021 A new AXI acceptance SHALL be possible in the cycle after the response handshake, with no combinational ready-to-valid path.
REQ-022 Minimum latency with stall = 0 and ack one cycle after stb: acceptance at cycle N -> stb at N+1 -> ack at N+2 -> bvalid/rvalid at N+3.
REQ-023 There SHALL be no timeout; the block SHALL wait in WB_REQ or WB_WAIT indefinitely.

Reset
REQ-024 While i_rst_n = 0, the state SHALL be IDLE with the following outputs at 0: cyc, stb, we, adr, dat_w, sel, awready, wready, arready, bvalid, rvalid, bresp, rresp and rdata; the round-robin pointer SHALL be reset to favour write.
REQ-025 Reset asserted mid-transaction SHALL abort it immediately: cyc/stb/bvalid/rvalid SHALL be 0 asynchronously, and no response SHALL be issued after release.

Verification
REQ-026 Write addr 0x10, data 0xA5A5_0001, wstrb 0xF, stall=0, ack after 1 cycle -> one stb cycle with we=1, sel=0xF; bvalid at N+3 with bresp=OKAY.
REQ-027 Read addr 0x14, stall=1 for 3 cycles, then ack with dat_r=0x1234_5678 -> adr stable during stall; rvalid with rdata=0x1234_5678 and rresp=OKAY.
REQ-028 Read with err and dat_r=0xDEAD_BEEF -> rresp=SLVERR and rdata=0xDEAD_BEEF; separately, write terminated by rty -> bresp=SLVERR.
REQ-029 Write pair and read both valid in IDLE, twice in a row -> first grant write, second grant read; awvalid without wvalid -> no awready.
REQ-030 bready held low for 5 cycles -> bvalid, bresp stable; no new acceptance until the handshake; arvalid waiting -> arready the cycle after the handshake.
REQ-031 i_rst_n pulsed low in WB_WAIT -> cyc=0 immediately; after release a late ack produces no bvalid/rvalid.
